mem_bus_arbiter: RTL and testbench

Single-port memory bus arbiter between the CPU core and a DMA/video requester, using cycle stealing. The CPU keeps priority and fixed cycle timing. DMA transfers run in cycles where the CPU does not touch memory. A starvation counter forces a DMA slot, holding the CPU, after a bounded number of contended CPU cycles. The block sits between the CPU's r/w/address/data pins and the external memory.

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: cycle-stealing arbiter for one memory port shared by the
// CPU (zero-latency, priority) and a DMA/video requester (one access per two
// cycles at best). A starvation counter forces a DMA slot after
// CPU_BURST_MAX contended CPU grants and holds the CPU for that one cycle.
module mem_bus_arbiter #(
    parameter int unsigned CPU_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_hold,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_r,
    output logic        mem_w
);

    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST_MAX);

    typedef enum logic {
        ARB  = 1'b0,
        DACK = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        cpu_acc;
    logic        dma_elig;
    logic        force_dma;
    logic        grant_dma;
    logic        grant_cpu;

    // Grant decision; reset gates both requesters so the port is idle while reset is high
    always_comb begin
        cpu_acc   = (cpu_r | cpu_w) & ~reset;
        dma_elig  = dma_req & (state_q == ARB) & ~reset;
        force_dma = dma_elig & (starve_q == BURST_MAX);
        grant_dma = dma_elig & (~cpu_acc | force_dma);
        grant_cpu = cpu_acc & ~grant_dma;
        cpu_hold  = cpu_acc & grant_dma;
    end

    // Memory port mux; a CPU cycle with both strobes set is treated as a write
    always_comb begin
        mem_address = 16'h0000;
        mem_wdata   = 8'h00;
        mem_r       = 1'b0;
        mem_w       = 1'b0;
        cpu_data_in = 8'h00;
        if (grant_cpu) begin
            mem_address = cpu_address;
            mem_wdata   = cpu_data_out;
            mem_w       = cpu_w;
            mem_r       = cpu_r & ~cpu_w;
            cpu_data_in = mem_rdata;
        end else if (grant_dma) begin
            mem_address = dma_address;
            mem_wdata   = dma_wdata;
            mem_w       = dma_we;
            mem_r       = ~dma_we;
        end
    end

    // Next-state logic: DMA access in ARB, one-cycle ack in DACK, starvation counting
    always_comb begin
        state_d     = state_q;
        dma_ack_d   = 1'b0;
        dma_rdata_d = dma_rdata_q;
        starve_d    = starve_q;

        case (state_q)
            ARB: begin
                if (grant_dma) begin
                    state_d   = DACK;
                    dma_ack_d = 1'b1;
                    if (!dma_we) begin
                        dma_rdata_d = mem_rdata;
                    end
                end
            end
            DACK: begin
                // DMA is ineligible here, so the CPU always owns this cycle
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (grant_dma || ((state_q == ARB) && !dma_req)) begin
            starve_d = 4'd0;
        end else if (grant_cpu && dma_elig && (starve_q != BURST_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State register; reset drops any in-flight DMA access without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            starve_q    <= 4'd0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            dma_ack_q   <= dma_ack_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors for mem_bus_arbiter. The driver applies
// one vector per cycle and queues the hand-computed outputs for that cycle
// (and the expected ack data for each DMA grant); two monitors pop and compare.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_r;
    logic        cpu_w;
    logic [7:0]  cpu_data_in;
    logic        cpu_hold;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_r;
    logic        mem_w;

    mem_bus_arbiter #(.CPU_BURST_MAX(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_r        (cpu_r),
        .cpu_w        (cpu_w),
        .cpu_data_in  (cpu_data_in),
        .cpu_hold     (cpu_hold),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_address  (dma_address),
        .dma_wdata    (dma_wdata),
        .dma_ack      (dma_ack),
        .dma_rdata    (dma_rdata),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_r        (mem_r),
        .mem_w        (mem_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [7:0]  wd;
        logic        r;
        logic        w;
        logic [7:0]  cdi;
        logic        h;
        logic        ack;
        logic [7:0]  rd;
    } exp_t;

    typedef struct {
        string      nm;
        logic [7:0] rd;
    } ack_t;

    exp_t exp_q[$];
    ack_t ack_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input string field,
                                input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, exp);
        end
    endfunction

    // One cycle of stimulus plus the expected outputs for that same cycle
    task automatic step(input string nm, input logic rst,
                        input logic cr, input logic cw,
                        input logic [15:0] ca, input logic [7:0] cd,
                        input logic dq, input logic dw,
                        input logic [15:0] da, input logic [7:0] dd,
                        input logic [7:0] mrd,
                        input logic [15:0] ea, input logic [7:0] ewd,
                        input logic er, input logic ew, input logic [7:0] ecdi,
                        input logic eh, input logic eack, input logic [7:0] erd,
                        input logic push_ack, input logic [7:0] ack_rd);
        exp_t e;
        ack_t k;
        @(posedge clk);
        #1;
        reset        = rst;
        cpu_r        = cr;
        cpu_w        = cw;
        cpu_address  = ca;
        cpu_data_out = cd;
        dma_req      = dq;
        dma_we       = dw;
        dma_address  = da;
        dma_wdata    = dd;
        mem_rdata    = mrd;
        e.nm  = nm;
        e.a   = ea;
        e.wd  = ewd;
        e.r   = er;
        e.w   = ew;
        e.cdi = ecdi;
        e.h   = eh;
        e.ack = eack;
        e.rd  = erd;
        exp_q.push_back(e);
        if (push_ack) begin
            k.nm = nm;
            k.rd = ack_rd;
            ack_q.push_back(k);
        end
    endtask

    // Per-cycle monitor: compares every output against the queued vector
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "mem_address", mem_address, e.a);
            chk(e.nm, "mem_wdata", {8'h00, mem_wdata}, {8'h00, e.wd});
            chk(e.nm, "mem_r", {15'h0, mem_r}, {15'h0, e.r});
            chk(e.nm, "mem_w", {15'h0, mem_w}, {15'h0, e.w});
            chk(e.nm, "cpu_data_in", {8'h00, cpu_data_in}, {8'h00, e.cdi});
            chk(e.nm, "cpu_hold", {15'h0, cpu_hold}, {15'h0, e.h});
            chk(e.nm, "dma_ack", {15'h0, dma_ack}, {15'h0, e.ack});
            chk(e.nm, "dma_rdata", {8'h00, dma_rdata}, {8'h00, e.rd});
        end
    end

    // Ack monitor: each dma_ack pulse must match a queued grant and its read data
    always @(negedge clk) begin
        ack_t k;
        if (dma_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_unexpected: got dma_ack=1 with rdata 0x%0h, required no ack", dma_rdata);
            end else begin
                k = ack_q.pop_front();
                chk(k.nm, "ack_rdata", {8'h00, dma_rdata}, {8'h00, k.rd});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        cpu_r        = 1'b0;
        cpu_w        = 1'b0;
        cpu_address  = 16'h0000;
        cpu_data_out = 8'h00;
        dma_req      = 1'b0;
        dma_we       = 1'b0;
        dma_address  = 16'h0000;
        dma_wdata    = 8'h00;
        mem_rdata    = 8'h00;

        // Reset forces every output idle even with requests present
        step("rst_idle_a", 1, 1,0,16'h1234,8'h00, 1,0,16'h0000,8'h00, 8'h55,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h00, 0,8'h00);
        step("rst_idle_b", 1, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h00, 0,8'h00);
        step("idle",       0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h00, 0,8'h00);

        // CPU-only accesses
        step("cpu_rd",     0, 1,0,16'h1234,8'h00, 0,0,16'h0000,8'h00, 8'hA5,
             16'h1234,8'h00,1,0,8'hA5,0,0,8'h00, 0,8'h00);
        step("cpu_wr",     0, 0,1,16'h2345,8'h5A, 0,0,16'h0000,8'h00, 8'h11,
             16'h2345,8'h5A,0,1,8'h11,0,0,8'h00, 0,8'h00);
        step("cpu_rw",     0, 1,1,16'h0F0F,8'h99, 0,0,16'h0000,8'h00, 8'h00,
             16'h0F0F,8'h99,0,1,8'h00,0,0,8'h00, 0,8'h00);

        // DMA write while the CPU is idle
        step("dma_wr",     0, 0,0,16'h0000,8'h00, 1,1,16'h8000,8'h3C, 8'h00,
             16'h8000,8'h3C,0,1,8'h00,0,0,8'h00, 1,8'h00);
        step("dma_wr_ack", 0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,1,8'h00, 0,8'h00);
        step("dma_wr_post",0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h00, 0,8'h00);

        // Contended: CPU wins 4 cycles, then DMA read is forced with a hold
        for (int k = 0; k < 4; k++) begin
            step("starve_cpu", 0, 1,0,16'h0100 + 16'(k),8'h00, 1,0,16'h0010,8'h00, 8'h77,
                 16'h0100 + 16'(k),8'h00,1,0,8'h77,0,0,8'h00, 0,8'h00);
        end
        step("starve_force",0, 1,0,16'h0104,8'h00, 1,0,16'h0010,8'h00, 8'h77,
             16'h0010,8'h00,1,0,8'h00,1,0,8'h00, 1,8'h77);
        step("starve_ack", 0, 1,0,16'h0104,8'h00, 0,0,16'h0000,8'h00, 8'h77,
             16'h0104,8'h00,1,0,8'h77,0,1,8'h77, 0,8'h00);
        step("starve_post",0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h77, 0,8'h00);

        // Continuous DMA reads, CPU idle: grant, ack, grant, ack...
        step("cont_gnt0",  0, 0,0,16'h0000,8'h00, 1,0,16'h4000,8'h00, 8'h01,
             16'h4000,8'h00,1,0,8'h00,0,0,8'h77, 1,8'h01);
        step("cont_ack0",  0, 0,0,16'h0000,8'h00, 1,0,16'h4000,8'h00, 8'h02,
             16'h0000,8'h00,0,0,8'h00,0,1,8'h01, 0,8'h00);
        step("cont_gnt1",  0, 0,0,16'h0000,8'h00, 1,0,16'h4000,8'h00, 8'h03,
             16'h4000,8'h00,1,0,8'h00,0,0,8'h01, 1,8'h03);
        step("cont_ack1",  0, 0,0,16'h0000,8'h00, 1,0,16'h4000,8'h00, 8'h04,
             16'h0000,8'h00,0,0,8'h00,0,1,8'h03, 0,8'h00);
        step("cont_gnt2",  0, 0,0,16'h0000,8'h00, 1,0,16'h4000,8'h00, 8'h05,
             16'h4000,8'h00,1,0,8'h00,0,0,8'h03, 1,8'h05);
        step("cont_ack2",  0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,1,8'h05, 0,8'h00);
        step("cont_post",  0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h05, 0,8'h00);

        // Build up the starvation count, then reset in a would-be DMA grant cycle
        step("pre_rst_cpu0",0, 1,0,16'h0200,8'h00, 1,0,16'h6000,8'h00, 8'hEE,
             16'h0200,8'h00,1,0,8'hEE,0,0,8'h05, 0,8'h00);
        step("pre_rst_cpu1",0, 1,0,16'h0201,8'h00, 1,0,16'h6000,8'h00, 8'hEE,
             16'h0201,8'h00,1,0,8'hEE,0,0,8'h05, 0,8'h00);
        step("rst_at_grant",1, 0,0,16'h0000,8'h00, 1,0,16'h6000,8'h00, 8'hEE,
             16'h0000,8'h00,0,0,8'h00,0,0,8'h05, 0,8'h00);

        // No ack after reset; counter restarted so four CPU grants precede the forced slot
        for (int k = 0; k < 4; k++) begin
            step("post_rst_cpu", 0, 1,0,16'h0202 + 16'(k),8'h00, 1,0,16'h6000,8'h00, 8'hEE,
                 16'h0202 + 16'(k),8'h00,1,0,8'hEE,0,0,8'h00, 0,8'h00);
        end
        step("post_rst_force",0, 1,0,16'h0206,8'h00, 1,0,16'h6000,8'h00, 8'hEE,
             16'h6000,8'h00,1,0,8'h00,1,0,8'h00, 1,8'hEE);
        step("post_rst_ack", 0, 1,0,16'h0206,8'h00, 0,0,16'h0000,8'h00, 8'hEE,
             16'h0206,8'h00,1,0,8'hEE,0,1,8'hEE, 0,8'h00);
        step("final_idle",   0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 8'h00,
             16'h0000,8'h00,0,0,8'h00,0,0,8'hEE, 0,8'h00);

        // Let the monitors drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d vectors unchecked, required 0", exp_q.size());
        end
        chk("end", "acks_outstanding", 16'(ack_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
